wb_cmd_master: RTL and testbench

- Single-outstanding Wishbone pipelined master. Sits directly upstream of the generated register banks and drives their wb_* slave port.
- Turns a simple request/response handshake from local control logic (sequencer, debug bridge) into one WB classic-pipelined transaction at a time.
- Honours stall and ack/err/rty, handles slaves that ack several cycles after the strobe, and returns read data and status on a one-cycle response pulse.

---
 rtl/wb_cmd_master.sv | 147 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone pipelined master.
// Converts a local request/response handshake into one classic-pipelined
// bus transaction at a time and returns status on a one-cycle pulse.
// Optional build macro WB_MASTER_TIMEOUT_EN adds a per-transaction abort
// counter of TIMEOUT_CYCLES bus cycles; without it the master waits forever.
module wb_cmd_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_adr_i,
   input  logic [3:0]            req_sel_i,
   input  logic [31:0]           req_dat_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_dat_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [3:0]            wb_sel_o,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic                  wb_rty_i,
   input  logic                  wb_stall_i
);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

   state_t state;
   state_t state_nxt;

   logic busy;
   logic accept;
   logic term;
   logic expire;

   assign busy   = (state == STROBE) || (state == WAIT);
   assign accept = req_i && req_ready_o;
   assign term   = busy && (wb_ack_i || wb_err_i || wb_rty_i);

`ifdef WB_MASTER_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // Count bus cycles of the current transaction; restarts on every accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt <= '0;
      end else if (accept) begin
         tmo_cnt <= '0;
      end else if (busy) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   // A real termination in the expiry cycle always beats the timeout.
   assign expire = busy && !term && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   // Timeout flag is part of the held response status.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_timeout_o <= 1'b0;
      end else if (term) begin
         rsp_timeout_o <= 1'b0;
      end else if (expire) begin
         rsp_timeout_o <= 1'b1;
      end
   end
`else
   assign expire        = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; termination is checked before stall in STROBE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = STROBE;
         end
         STROBE: begin
            if (term || expire) state_nxt = RESP;
            else if (!wb_stall_i) state_nxt = WAIT;
         end
         WAIT: begin
            if (term || expire) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // All outputs are registered from the next state so no wb_* input reaches an output combinationally.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_ready_o <= 1'b1;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_sel_o    <= '0;
         wb_dat_o    <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_dat_o   <= '0;
      end else begin
         req_ready_o <= (state_nxt == IDLE);
         wb_cyc_o    <= (state_nxt == STROBE) || (state_nxt == WAIT);
         wb_stb_o    <= (state_nxt == STROBE);
         rsp_valid_o <= (state_nxt == RESP);
         if (accept) begin
            wb_we_o  <= req_we_i;
            wb_adr_o <= req_adr_i;
            wb_sel_o <= req_sel_i;
            wb_dat_o <= req_dat_i;
         end
         if (term) begin
            rsp_err_o <= wb_err_i || wb_rty_i;
            rsp_dat_o <= (wb_ack_i && !wb_err_i && !wb_rty_i && !wb_we_o) ? wb_dat_i : 32'h0;
         end else if (expire) begin
            rsp_err_o <= 1'b1;
            rsp_dat_o <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed scenarios plus randomized
// transactions, with expected results derived from the bus protocol rules.
// Build with WB_MASTER_TIMEOUT_EN defined to exercise the abort path.
module tb_wb_cmd_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [7:0]  req_adr_i;
   logic [3:0]  req_sel_i;
   logic [31:0] req_dat_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [7:0]  wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_rty_i;
   logic        wb_stall_i;

   int checks = 0;
   int errors = 0;

   wb_cmd_master #(
      .ADDR_WIDTH(8),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req_i(req_i),
      .req_ready_o(req_ready_o),
      .req_we_i(req_we_i),
      .req_adr_i(req_adr_i),
      .req_sel_i(req_sel_i),
      .req_dat_i(req_dat_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_dat_o(rsp_dat_o),
      .rsp_err_o(rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o),
      .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o),
      .wb_sel_o(wb_sel_o),
      .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i),
      .wb_rty_i(wb_rty_i),
      .wb_stall_i(wb_stall_i)
   );

   // Free-running 100 MHz clock.
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One transaction. The slave stalls for 'stalls' strobe cycles and terminates
   // 'lat' cycles after the first strobe cycle. kind: 0 ack, 1 err, 2 rty, 3 ack+err.
   task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input int stalls, input int lat,
                                input int kind, input logic [31:0] rdata);
      logic        exp_err;
      logic [31:0] exp_dat;
      exp_err = (kind != 0);
      exp_dat = (kind == 0 && !we) ? rdata : 32'h0;
      @(negedge clk_i);
      checkOutput("ready_before_req", req_ready_o, 1);
      req_i     = 1'b1;
      req_we_i  = we;
      req_adr_i = adr;
      req_sel_i = sel;
      req_dat_i = dat;
      @(negedge clk_i);
      req_i     = 1'b0;
      req_we_i  = ~we;
      req_adr_i = ~adr;
      req_sel_i = ~sel;
      req_dat_i = ~dat;
      checkOutput("ready_busy", req_ready_o, 0);
      checkOutput("wb_we", wb_we_o, we);
      checkOutput("wb_sel", wb_sel_o, sel);
      checkOutput("wb_dat", wb_dat_o, dat);
      for (int n = 0; n <= lat; n++) begin
         if (n > 0) @(negedge clk_i);
         checkOutput("cyc_busy", wb_cyc_o, 1);
         checkOutput("stb_phase", wb_stb_o, (n <= stalls));
         checkOutput("adr_stable", wb_adr_o, adr);
         checkOutput("no_early_rsp", rsp_valid_o, 0);
         wb_stall_i = (n < stalls);
         wb_dat_i   = (n == lat) ? rdata : $urandom;
         wb_ack_i   = (n == lat) && (kind == 0 || kind == 3);
         wb_err_i   = (n == lat) && (kind == 1 || kind == 3);
         wb_rty_i   = (n == lat) && (kind == 2);
      end
      @(negedge clk_i);
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_rty_i   = 1'b0;
      wb_stall_i = 1'b0;
      wb_dat_i   = $urandom;
      checkOutput("cyc_end", wb_cyc_o, 0);
      checkOutput("stb_end", wb_stb_o, 0);
      checkOutput("rsp_valid", rsp_valid_o, 1);
      checkOutput("rsp_err", rsp_err_o, exp_err);
      checkOutput("rsp_timeout", rsp_timeout_o, 0);
      checkOutput("rsp_dat", rsp_dat_o, exp_dat);
      @(negedge clk_i);
      checkOutput("rsp_pulse_one", rsp_valid_o, 0);
      checkOutput("ready_after", req_ready_o, 1);
      checkOutput("rsp_err_hold", rsp_err_o, exp_err);
      checkOutput("rsp_dat_hold", rsp_dat_o, exp_dat);
   endtask

   // Hard stop in case any scenario wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      logic [7:0]  bb_adr [4];
      logic [31:0] bb_dat [4];
      int busy_cycles;
      int bad;
      int got;
      int bus_seen;
      int rsp_seen;
      int gap;
      logic prev_cyc;

      rst_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_sel_i = '0;
      req_dat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      wb_stall_i = 1'b0;
      #1;
      checkOutput("reset_ready", req_ready_o, 1);
      checkOutput("reset_cyc", wb_cyc_o, 0);
      checkOutput("reset_stb", wb_stb_o, 0);
      checkOutput("reset_rsp_valid", rsp_valid_o, 0);
      checkOutput("reset_rsp_err", rsp_err_o, 0);
      checkOutput("reset_rsp_dat", rsp_dat_o, 0);
      checkOutput("reset_wb_adr", wb_adr_o, 0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // Terminations while no bus cycle is open must be ignored.
      for (int i = 0; i < 3; i++) begin
         wb_ack_i = 1'b1; wb_err_i = 1'b1;
         @(negedge clk_i);
         checkOutput("idle_ack_ignored", rsp_valid_o, 0);
         checkOutput("idle_cyc", wb_cyc_o, 0);
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0;

      $display("[TB] directed write/read/error cases");
      applyStimulus(1'b1, 8'h00, 4'hF, 32'h0000_0002, 2, 3, 0, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 8'h04, 4'hF, 32'h0, 0, 3, 0, 32'h0000_0002);
      applyStimulus(1'b0, 8'h08, 4'hF, 32'h0, 0, 1, 3, 32'h1234_5678);
      applyStimulus(1'b0, 8'h0C, 4'h3, 32'h0, 1, 2, 2, 32'h5555_AAAA);
      applyStimulus(1'b0, 8'h10, 4'hF, 32'h0, 3, 0, 0, 32'hCAFE_F00D);

      $display("[TB] reset in the middle of a transaction");
      @(negedge clk_i);
      req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 8'h20; req_sel_i = 4'hF;
      @(negedge clk_i);
      req_i = 1'b0;
      @(negedge clk_i);
      checkOutput("pre_reset_cyc", wb_cyc_o, 1);
      checkOutput("pre_reset_stb", wb_stb_o, 0);
      #2 rst_i = 1'b1;
      #1;
      checkOutput("async_reset_cyc", wb_cyc_o, 0);
      checkOutput("async_reset_stb", wb_stb_o, 0);
      checkOutput("async_reset_ready", req_ready_o, 1);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checkOutput("post_reset_no_rsp", rsp_valid_o, 0);
         checkOutput("post_reset_cyc", wb_cyc_o, 0);
      end
      applyStimulus(1'b1, 8'h24, 4'hC, 32'hA5A5_0001, 0, 2, 0, 32'h0);

      $display("[TB] unterminated transaction");
      @(negedge clk_i);
      req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 8'h30; req_sel_i = 4'hF;
      @(negedge clk_i);
      req_i = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      busy_cycles = 0;
      got = 0;
      for (int i = 0; i < 30 && got == 0; i++) begin
         if (rsp_valid_o) got = 1;
         else begin
            if (wb_cyc_o) busy_cycles++;
            @(negedge clk_i);
         end
      end
      checkOutput("tmo_rsp_seen", got, 1);
      checkOutput("tmo_busy_cycles", busy_cycles, 8);
      checkOutput("tmo_cyc", wb_cyc_o, 0);
      checkOutput("tmo_err", rsp_err_o, 1);
      checkOutput("tmo_flag", rsp_timeout_o, 1);
      checkOutput("tmo_dat", rsp_dat_o, 0);
      wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checkOutput("late_ack_ignored", rsp_valid_o, 0);
      end
      wb_ack_i = 1'b0;
`else
      busy_cycles = 0;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         if (wb_cyc_o) busy_cycles++;
         if (rsp_valid_o) bad++;
         @(negedge clk_i);
      end
      checkOutput("no_tmo_cyc_held", busy_cycles, 1000);
      checkOutput("no_tmo_no_rsp", bad, 0);
      wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_CAFE;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      checkOutput("no_tmo_final_rsp", rsp_valid_o, 1);
      checkOutput("no_tmo_final_dat", rsp_dat_o, 32'h0BAD_CAFE);
      checkOutput("no_tmo_flag", rsp_timeout_o, 0);
`endif
      @(negedge clk_i);

      $display("[TB] back-to-back writes with req held high");
      for (int i = 0; i < 4; i++) begin
         bb_adr[i] = 8'($urandom);
         bb_dat[i] = $urandom;
      end
      bus_seen = 0; rsp_seen = 0; gap = 0; prev_cyc = 1'b0;
      req_i = 1'b1; req_we_i = 1'b1; req_sel_i = 4'hF;
      req_adr_i = bb_adr[0]; req_dat_i = bb_dat[0];
      for (int cyc = 0; cyc < 80 && rsp_seen < 4; cyc++) begin
         @(negedge clk_i);
         wb_ack_i = 1'b0;
         if (wb_cyc_o && !prev_cyc) begin
            if (bus_seen > 0) checkOutput("bb_cyc_gap", (gap >= 1), 1);
            if (bus_seen < 4) begin
               checkOutput("bb_adr_order", wb_adr_o, bb_adr[bus_seen]);
               checkOutput("bb_dat_order", wb_dat_o, bb_dat[bus_seen]);
            end else begin
               checkOutput("bb_extra_txn", bus_seen, 3);
            end
            bus_seen++;
            if (bus_seen < 4) begin
               req_adr_i = bb_adr[bus_seen];
               req_dat_i = bb_dat[bus_seen];
            end else begin
               req_i = 1'b0;
            end
         end
         if (wb_cyc_o && wb_stb_o) wb_ack_i = 1'b1;
         if (rsp_valid_o) begin
            checkOutput("bb_rsp_err", rsp_err_o, 0);
            checkOutput("bb_rsp_cyc_low", wb_cyc_o, 0);
            rsp_seen++;
         end
         gap = wb_cyc_o ? 0 : gap + 1;
         prev_cyc = wb_cyc_o;
      end
      wb_ack_i = 1'b0;
      req_i = 1'b0;
      checkOutput("bb_rsp_count", rsp_seen, 4);
      checkOutput("bb_txn_count", bus_seen, 4);
      @(negedge clk_i);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 25; t++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
